// File: rtl/decode_stage.sv
// ID stage of the pipelined MIPS core: decodes IF/ID into the ID/EX register, detects load-use hazards, counts stalls.
// Optional opcodes (bltz, ble, sltiu, ori) are decoded only when DECODE_EXT_OPS_EN is defined.
module decode_stage #(
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           instr_i,
    input  logic                  instr_valid_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  ex_valid_o,
    output logic                  ex_reg_write_o,
    output logic                  ex_alu_src_o,
    output logic                  ex_alu_signed_o,
    output logic                  ex_branch_o,
    output logic                  ex_jump_o,
    output logic                  ex_mem_read_o,
    output logic                  ex_mem_write_o,
    output logic                  ex_illegal_o,
    output logic [ALU_OP_W-1:0]   ex_alu_op_o,
    output logic [1:0]            ex_reg_dst_o,
    output logic [1:0]            ex_branch_type_o,
    output logic [1:0]            ex_mem_to_reg_o,
    output logic [REG_ADDR_W-1:0] ex_rs_o,
    output logic [REG_ADDR_W-1:0] ex_rt_o,
    output logic [REG_ADDR_W-1:0] ex_rd_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  alu_src;
        logic                  alu_signed;
        logic                  branch;
        logic                  jump;
        logic                  mem_read;
        logic                  mem_write;
        logic                  illegal;
        logic [ALU_OP_W-1:0]   alu_op;
        logic [1:0]            reg_dst;
        logic [1:0]            branch_type;
        logic [1:0]            mem_to_reg;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] rd;
    } idex_t;

    idex_t            ex_q, ex_d, dec;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       opcode;
    logic             rs_src, rt_src, hazard, stall;

    assign opcode = instr_i[31:26];

    always_comb begin
        dec            = '0;
        dec.valid      = 1'b1;
        dec.alu_signed = 1'b1;
        dec.rs         = REG_ADDR_W'(instr_i[25:21]);
        dec.rt         = REG_ADDR_W'(instr_i[20:16]);
        dec.rd         = REG_ADDR_W'(instr_i[15:11]);
        rt_src         = 1'b0;
        case (opcode)
            6'd0: begin
                dec.reg_write = 1'b1;
                dec.reg_dst   = 2'b01;
                dec.alu_op    = ALU_OP_W'(3'b010);
                rt_src        = 1'b1;
            end
            6'd2: dec.jump = 1'b1;
            6'd3: begin
                dec.jump       = 1'b1;
                dec.reg_write  = 1'b1;
                dec.reg_dst    = 2'b10;
                dec.mem_to_reg = 2'b10;
            end
            6'd4, 6'd5: begin
                dec.branch      = 1'b1;
                dec.alu_op      = ALU_OP_W'(3'b001);
                dec.branch_type = {1'b0, opcode[0]};
                rt_src          = 1'b1;
            end
            6'd8: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
            end
            6'd35: begin
                dec.mem_read   = 1'b1;
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.mem_to_reg = 2'b01;
            end
            6'd43: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                rt_src        = 1'b1;
            end
`ifdef DECODE_EXT_OPS_EN
            6'd1: begin
                dec.branch      = 1'b1;
                dec.branch_type = 2'b11;
                dec.alu_op      = ALU_OP_W'(3'b001);
            end
            6'd6: begin
                dec.branch      = 1'b1;
                dec.branch_type = 2'b10;
                dec.alu_op      = ALU_OP_W'(3'b001);
                rt_src          = 1'b1;
            end
            6'd9, 6'd13: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.alu_signed = 1'b0;
                dec.alu_op     = (opcode == 6'd9) ? ALU_OP_W'(3'b011) : ALU_OP_W'(3'b100);
            end
`endif
            default: begin
                dec.alu_signed = 1'b0;
                dec.illegal    = 1'b1;
            end
        endcase
    end

    // Jumps carry target bits in the rs/rt fields, so they never read registers.
    assign rs_src = (opcode != 6'd2) && (opcode != 6'd3);

    assign hazard = instr_valid_i && ex_q.valid && ex_q.mem_read && (ex_q.rt != '0) &&
                    ((rs_src && (ex_q.rt == dec.rs)) || (rt_src && (ex_q.rt == dec.rt)));
    assign stall  = hazard && !flush_i;

    always_comb begin
        ex_d = dec;
        if (flush_i || hazard || !instr_valid_i) begin
            ex_d = '0;
        end
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign stall_o          = stall;
    assign ex_valid_o       = ex_q.valid;
    assign ex_reg_write_o   = ex_q.reg_write;
    assign ex_alu_src_o     = ex_q.alu_src;
    assign ex_alu_signed_o  = ex_q.alu_signed;
    assign ex_branch_o      = ex_q.branch;
    assign ex_jump_o        = ex_q.jump;
    assign ex_mem_read_o    = ex_q.mem_read;
    assign ex_mem_write_o   = ex_q.mem_write;
    assign ex_illegal_o     = ex_q.illegal;
    assign ex_alu_op_o      = ex_q.alu_op;
    assign ex_reg_dst_o     = ex_q.reg_dst;
    assign ex_branch_type_o = ex_q.branch_type;
    assign ex_mem_to_reg_o  = ex_q.mem_to_reg;
    assign ex_rs_o          = ex_q.rs;
    assign ex_rt_o          = ex_q.rt;
    assign ex_rd_o          = ex_q.rd;
    assign stall_cnt_o      = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage: driver pushes expected per-cycle observations, a negedge monitor checks them.
module tb_decode_stage;

    localparam int CW = 4;

    // Control layout: valid rw alu_src signed branch jump mem_rd mem_wr illegal | alu_op | reg_dst | btype | m2r
    localparam logic [17:0] C_BUB   = 18'b0;
    localparam logic [17:0] C_RTYPE = 18'b1_1_0_1_0_0_0_0_0_010_01_00_00;
    localparam logic [17:0] C_LW    = 18'b1_1_1_1_0_0_1_0_0_000_00_00_01;
    localparam logic [17:0] C_ADDI  = 18'b1_1_1_1_0_0_0_0_0_000_00_00_00;
    localparam logic [17:0] C_J     = 18'b1_0_0_1_0_1_0_0_0_000_00_00_00;
    localparam logic [17:0] C_JAL   = 18'b1_1_0_1_0_1_0_0_0_000_10_00_10;
    localparam logic [17:0] C_BEQ   = 18'b1_0_0_1_1_0_0_0_0_001_00_00_00;
    localparam logic [17:0] C_BNE   = 18'b1_0_0_1_1_0_0_0_0_001_00_01_00;
    localparam logic [17:0] C_SW    = 18'b1_0_1_1_0_0_0_1_0_000_00_00_00;
    localparam logic [17:0] C_ILL   = 18'b1_0_0_0_0_0_0_0_1_000_00_00_00;
    localparam logic [17:0] C_BLE   = 18'b1_0_0_1_1_0_0_0_0_001_00_10_00;
    localparam logic [17:0] C_SLTIU = 18'b1_1_1_0_0_0_0_0_0_011_00_00_00;

    localparam logic [31:0] I_LW8   = 32'h8C08_0000;  // lw   $8,0($0)
    localparam logic [31:0] I_LW0   = 32'h8C00_0000;  // lw   $0,0($0)
    localparam logic [31:0] I_ADD   = 32'h0101_4820;  // add  $9,$8,$1
    localparam logic [31:0] I_ADD0  = 32'h0000_4820;  // add  $9,$0,$0
    localparam logic [31:0] I_J     = 32'h0908_0000;  // j with 8s in rs/rt fields
    localparam logic [31:0] I_ADDI  = 32'h2109_0005;  // addi $9,$8,5
    localparam logic [31:0] I_ADDI8 = 32'h2048_0001;  // addi $8,$2,1
    localparam logic [31:0] I_SW    = 32'hAC48_0000;  // sw   $8,0($2)
    localparam logic [31:0] I_JAL   = 32'h0C00_0010;  // jal  0x40
    localparam logic [31:0] I_BEQ   = 32'h1022_0003;
    localparam logic [31:0] I_BNE   = 32'h1422_0003;
    localparam logic [31:0] I_BLE   = 32'h1822_0003;
    localparam logic [31:0] I_SLTIU = 32'h2448_0007;
    localparam logic [31:0] I_BAD   = 32'hFC00_0000;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic [31:0]   instr_i = '0;
    logic          instr_valid_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          stall_o, ex_valid_o, ex_reg_write_o, ex_alu_src_o, ex_alu_signed_o;
    logic          ex_branch_o, ex_jump_o, ex_mem_read_o, ex_mem_write_o, ex_illegal_o;
    logic [2:0]    ex_alu_op_o;
    logic [1:0]    ex_reg_dst_o, ex_branch_type_o, ex_mem_to_reg_o;
    logic [4:0]    ex_rs_o, ex_rt_o, ex_rd_o;
    logic [CW-1:0] stall_cnt_o;

    decode_stage #(.REG_ADDR_W(5), .ALU_OP_W(3), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
        .flush_i(flush_i), .stall_o(stall_o), .ex_valid_o(ex_valid_o),
        .ex_reg_write_o(ex_reg_write_o), .ex_alu_src_o(ex_alu_src_o),
        .ex_alu_signed_o(ex_alu_signed_o), .ex_branch_o(ex_branch_o), .ex_jump_o(ex_jump_o),
        .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o),
        .ex_illegal_o(ex_illegal_o), .ex_alu_op_o(ex_alu_op_o), .ex_reg_dst_o(ex_reg_dst_o),
        .ex_branch_type_o(ex_branch_type_o), .ex_mem_to_reg_o(ex_mem_to_reg_o),
        .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Scoreboard entry: {stall, ex bundle (33), counter}
    logic [33+CW:0] exp_q[$];
    logic [32:0]    cur_ex = '0;
    logic [CW-1:0]  cur_cnt = '0;
    int             total = 0;
    int             bad = 0;
    int             ncyc = 0;

    function automatic logic [32:0] ex(input logic [17:0] c, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd);
        return {c, rs, rt, rd};
    endfunction

    task automatic cyc(input logic rst, input logic [31:0] ins, input logic v,
                       input logic fl, input logic st, input logic [32:0] nxt);
        @(posedge clk_i);
        #1;
        rst_i = rst;
        instr_i = ins;
        instr_valid_i = v;
        flush_i = fl;
        if (!rst) begin
            cur_ex  = '0;
            cur_cnt = '0;
        end
        exp_q.push_back({st, cur_ex, cur_cnt});
        if (rst) begin
            cur_ex = nxt;
            if (st && (cur_cnt != '1)) cur_cnt = cur_cnt + 1'b1;
        end
    endtask

    always @(negedge clk_i) begin
        logic [33+CW:0] e;
        logic [32:0]    got_ex;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got_ex = {ex_valid_o, ex_reg_write_o, ex_alu_src_o, ex_alu_signed_o, ex_branch_o,
                      ex_jump_o, ex_mem_read_o, ex_mem_write_o, ex_illegal_o, ex_alu_op_o,
                      ex_reg_dst_o, ex_branch_type_o, ex_mem_to_reg_o, ex_rs_o, ex_rt_o, ex_rd_o};
            total += 3;
            if (stall_o !== e[33+CW]) begin
                bad++;
                $display("FAIL stall cyc%0d: got %b want %b", ncyc, stall_o, e[33+CW]);
            end
            if (got_ex !== e[32+CW:CW]) begin
                bad++;
                $display("FAIL ex_bundle cyc%0d: got %h want %h", ncyc, got_ex, e[32+CW:CW]);
            end
            if (stall_cnt_o !== e[CW-1:0]) begin
                bad++;
                $display("FAIL stall_cnt cyc%0d: got %0d want %0d", ncyc, stall_cnt_o, e[CW-1:0]);
            end
            ncyc++;
        end
    end

    initial begin
        logic [32:0] n_ble, n_sltiu;
`ifdef DECODE_EXT_OPS_EN
        n_ble   = ex(C_BLE, 5'd1, 5'd2, 5'd0);
        n_sltiu = ex(C_SLTIU, 5'd2, 5'd8, 5'd0);
`else
        n_ble   = ex(C_ILL, 5'd1, 5'd2, 5'd0);
        n_sltiu = ex(C_ILL, 5'd2, 5'd8, 5'd0);
`endif
        // reset held, then released with idle IF/ID
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, '0);
        // load-use: lw $8 then add $9,$8,$1
        cyc(1'b1, I_LW8, 1'b1, 1'b0, 1'b0, ex(C_LW, 5'd0, 5'd8, 5'd0));
        cyc(1'b1, I_ADD, 1'b1, 1'b0, 1'b1, ex(C_BUB, 5'd0, 5'd0, 5'd0));
        cyc(1'b1, I_ADD, 1'b1, 1'b0, 1'b0, ex(C_RTYPE, 5'd8, 5'd1, 5'd9));
        // lw $0 never hazards
        cyc(1'b1, I_LW0, 1'b1, 1'b0, 1'b0, ex(C_LW, 5'd0, 5'd0, 5'd0));
        cyc(1'b1, I_ADD0, 1'b1, 1'b0, 1'b0, ex(C_RTYPE, 5'd0, 5'd0, 5'd9));
        // jump fields are not sources
        cyc(1'b1, I_LW8, 1'b1, 1'b0, 1'b0, ex(C_LW, 5'd0, 5'd8, 5'd0));
        cyc(1'b1, I_J, 1'b1, 1'b0, 1'b0, ex(C_J, 5'd8, 5'd8, 5'd0));
        // rs match on addi
        cyc(1'b1, I_LW8, 1'b1, 1'b0, 1'b0, ex(C_LW, 5'd0, 5'd8, 5'd0));
        cyc(1'b1, I_ADDI, 1'b1, 1'b0, 1'b1, '0);
        cyc(1'b1, I_ADDI, 1'b1, 1'b0, 1'b0, ex(C_ADDI, 5'd8, 5'd9, 5'd0));
        // rt is a source for sw but not for addi
        cyc(1'b1, I_LW8, 1'b1, 1'b0, 1'b0, ex(C_LW, 5'd0, 5'd8, 5'd0));
        cyc(1'b1, I_SW, 1'b1, 1'b0, 1'b1, '0);
        cyc(1'b1, I_SW, 1'b1, 1'b0, 1'b0, ex(C_SW, 5'd2, 5'd8, 5'd0));
        cyc(1'b1, I_LW8, 1'b1, 1'b0, 1'b0, ex(C_LW, 5'd0, 5'd8, 5'd0));
        cyc(1'b1, I_ADDI8, 1'b1, 1'b0, 1'b0, ex(C_ADDI, 5'd2, 5'd8, 5'd0));
        // hazard and flush together
        cyc(1'b1, I_LW8, 1'b1, 1'b0, 1'b0, ex(C_LW, 5'd0, 5'd8, 5'd0));
        cyc(1'b1, I_ADD, 1'b1, 1'b1, 1'b0, '0);
        cyc(1'b1, I_ADD, 1'b1, 1'b0, 1'b0, ex(C_RTYPE, 5'd8, 5'd1, 5'd9));
        // plain flush of a valid instruction
        cyc(1'b1, I_JAL, 1'b1, 1'b1, 1'b0, '0);
        cyc(1'b1, I_JAL, 1'b1, 1'b0, 1'b0, ex(C_JAL, 5'd0, 5'd0, 5'd0));
        cyc(1'b1, I_BEQ, 1'b1, 1'b0, 1'b0, ex(C_BEQ, 5'd1, 5'd2, 5'd0));
        cyc(1'b1, I_BNE, 1'b1, 1'b0, 1'b0, ex(C_BNE, 5'd1, 5'd2, 5'd0));
        cyc(1'b1, I_BLE, 1'b1, 1'b0, 1'b0, n_ble);
        cyc(1'b1, I_SLTIU, 1'b1, 1'b0, 1'b0, n_sltiu);
        cyc(1'b1, I_BAD, 1'b1, 1'b0, 1'b0, ex(C_ILL, 5'd0, 5'd0, 5'd0));
        // reset asserted in a stall cycle, then release
        cyc(1'b1, I_LW8, 1'b1, 1'b0, 1'b0, ex(C_LW, 5'd0, 5'd8, 5'd0));
        cyc(1'b0, I_ADD, 1'b1, 1'b0, 1'b0, '0);
        cyc(1'b1, I_ADD, 1'b1, 1'b0, 1'b0, ex(C_RTYPE, 5'd8, 5'd1, 5'd9));
        // 2^CW+3 stalls drive the counter into saturation
        for (int i = 0; i < (1 << CW) + 3; i++) begin
            cyc(1'b1, I_LW8, 1'b1, 1'b0, 1'b0, ex(C_LW, 5'd0, 5'd8, 5'd0));
            cyc(1'b1, I_ADD, 1'b1, 1'b0, 1'b1, '0);
        end
        cyc(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk_i);
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d entries left want 0", exp_q.size());
        end
        #2;
        total++;
        if (stall_cnt_o !== {CW{1'b1}}) begin
            bad++;
            $display("FAIL saturate: got %0d want %0d", stall_cnt_o, {CW{1'b1}});
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered instruction decode stage for the pipelined MIPS core. It decodes the IF/ID instruction into a full control bundle and holds it, with the register specifiers, in the ID/EX pipeline register. It performs load-use hazard detection against its own EX-stage contents and inserts a bubble with a one-cycle upstream stall. It honours branch/jump flushes from EX and counts stall cycles for the cache/pipeline statistics.

## Interface
- REG_ADDR_W, 5, register specifier width
- ALU_OP_W, 3, ALU-control opcode width (must be ≥3)
- CNT_W, 16, stall counter width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- instr_i  in  32  IF/ID instruction
- instr_valid_i  in  1  IF/ID holds a real instruction
- flush_i  in  1  branch taken / jump resolved in EX; kill ID
- stall_o  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid_o  out  1  ID/EX holds a real instruction
- ex_reg_write_o, ex_alu_src_o, ex_alu_signed_o, ex_branch_o, ex_jump_o, ex_mem_read_o, ex_mem_write_o, ex_illegal_o  out  1 each
- ex_alu_op_o  out  ALU_OP_W  000 add (lw/sw/addi), 001 sub/compare (branches), 010 R-type funct, 011 sltiu, 100 ori
- ex_reg_dst_o  out  2  00 rt, 01 rd, 10 $31
- ex_branch_type_o  out  2  00 beq, 01 bne, 10 ble, 11 bltz
- ex_mem_to_reg_o  out  2  00 ALU, 01 memory, 10 PC+4
- ex_rs_o, ex_rt_o, ex_rd_o  out  REG_ADDR_W  instr fields [25:21], [20:16], [15:11], truncated/zero-extended to REG_ADDR_W
- stall_cnt_o  out  CNT_W  saturating count of stall cycles

## Operation
- Base opcodes: 0 R-type (reg_write, reg_dst 01, alu 010), 2 j (jump), 3 jal (jump, reg_write, reg_dst 10, mem_to_reg 10), 4 beq / 5 bne (branch, alu 001), 8 addi (reg_write, alu_src, alu 000), 35 lw (mem_read, reg_write, alu_src, mem_to_reg 01), 43 sw (mem_write, alu_src).
- alu_signed = 1 for all except sltiu and ori (zero-extended immediate).
- Any other opcode: control all 0, ex_illegal_o=1, ex_valid_o=1.
- rt is a source for R-type, beq, bne, ble, sw; rs is a source for all except j, jal.
- Load-use hazard: stall_o=1 when instr_valid_i, ex_valid_o, ex_mem_read_o, ex_rt_o≠0, and ex_rt_o equals a source register of the ID instruction.
- Next-state priority:
  - flush_i: load a bubble (all outputs 0, valid 0); stall_o forced 0.
  - stall: load a bubble.
  - !instr_valid_i: load a bubble.
  - Otherwise: load the decode of instr_i.
- Bubble fields: rs/rt/rd zeroed.
- stall_cnt_o increments on each cycle with stall_o=1 and saturates at all-ones.

## Timing
- Reset (rst_i low, asynchronous): every ex_* output 0, stall_cnt_o 0; stall_o is 0 because ex_valid_o is 0.
- Decode latency: 1 cycle; instr_i sampled at edge N appears on ex_* after edge N.
- Load-use stall lasts exactly 1 cycle. The bubble clears ex_mem_read_o, so the held instruction issues on the next edge.
- flush_i and hazard in the same cycle: flush wins, stall_o=0, counter unchanged.
- Reset asserted mid-stall: outputs clear immediately; no stall after release until a new lw reaches EX.
- No other internal state; only the ID/EX register and counter.

## Configuration
- DECODE_EXT_OPS_EN defined: additionally decodes:
  - 1 bltz: branch, branch_type 11, alu 001
  - 6 ble: branch, branch_type 10, alu 001
  - 9 sltiu: reg_write, alu_src, alu 011, unsigned
  - 13 ori: reg_write, alu_src, alu 100, unsigned
- Undefined: these four opcodes decode as illegal (all control 0, ex_illegal_o=1).

## Test plan
- Reset release, instr_valid_i=0 for 3 cycles -> all ex_* 0, stall_o 0, stall_cnt_o 0.
- lw $8,0($0) then add $9,$8,$1 -> one cycle with stall_o=1, ex_valid_o=0 bubble, then add in EX with ex_alu_op_o=010, ex_reg_dst_o=01; stall_cnt_o=1.
- lw $0 followed by add using $0, and lw $8 followed by addi $9,$8... (rt not a source of j) -> j after lw $8: no stall; addi $9,$8: stall (rs match).
- Hazard plus flush_i=1 in the same cycle -> stall_o=0, bubble loaded, stall_cnt_o unchanged.
- jal 0x40 -> ex_jump_o=1, ex_reg_write_o=1, ex_reg_dst_o=10, ex_mem_to_reg_o=10.
- Opcode 6 (ble) with DECODE_EXT_OPS_EN -> ex_branch_o=1, ex_branch_type_o=10. Without the macro -> ex_illegal_o=1, all control 0. Force 2^CNT_W+3 stalls -> stall_cnt_o saturates at all-ones.
